// File: rtl/noc_link_if.sv
// Flit/credit handshake bundle for one NoC link direction.
// The master sends flits and receives credits; the slave receives flits and returns credits.
interface noc_link_if #(
    parameter int FLIT_WIDTH = 128,
    parameter int DEST_WIDTH = 6
);
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
    logic                  send;
    logic                  credit;

    modport master (output data, dest, is_tail, send, input credit);
    modport slave  (input data, dest, is_tail, send, output credit);
endinterface

// File: rtl/noc_pipeline_link.sv
// Credit-based retiming link: NUM_PIPELINE register stages for flits (forward) and credits (reverse),
// plus input-side packet framing and traffic counters. Optional credit checker: NOC_LINK_CREDIT_CHECK_EN.
module noc_pipeline_link #(
    parameter int NUM_PIPELINE      = 2,
    parameter int FLIT_WIDTH        = 128,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 1,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                 clk_noc,
    input  logic                 rst_n,
    noc_link_if.slave            up,
    noc_link_if.master           dn,
    output logic                 in_packet,
    output logic [CNT_WIDTH-1:0] flit_count,
    output logic [CNT_WIDTH-1:0] packet_count,
    output logic                 credit_err
);

    typedef struct packed {
        logic                  send;
        logic                  tail;
        logic [DEST_WIDTH-1:0] dest;
        logic [FLIT_WIDTH-1:0] data;
    } flit_t;

    typedef enum logic {
        IDLE,
        OPEN
    } frame_state_e;

    flit_t fwd_in;
    flit_t fwd_out;

    assign fwd_in      = '{send: up.send, tail: up.is_tail, dest: up.dest, data: up.data};
    assign dn.send     = fwd_out.send;
    assign dn.is_tail  = fwd_out.tail;
    assign dn.dest     = fwd_out.dest;
    assign dn.data     = fwd_out.data;

    if (NUM_PIPELINE == 0) begin : g_wire
        assign fwd_out   = fwd_in;
        assign up.credit = dn.credit;
    end else begin : g_pipe
        flit_t                   fwd_q [NUM_PIPELINE];
        flit_t                   fwd_d [NUM_PIPELINE];
        logic [NUM_PIPELINE-1:0] crd_q;
        logic [NUM_PIPELINE-1:0] crd_d;

        always_comb begin
            fwd_d[0] = fwd_in;
            crd_d[0] = dn.credit;
            for (int k = 1; k < NUM_PIPELINE; k++) begin
                fwd_d[k] = fwd_q[k-1];
                crd_d[k] = crd_q[k-1];
            end
        end

        // NOTE: payload stages are reset too (not just send) so data/dest read 0 while in reset;
        // <= lets every stage shift from its pre-edge neighbour in one clock.
        always_ff @(posedge clk_noc or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < NUM_PIPELINE; k++) fwd_q[k] <= '0;
                crd_q <= '0;
            end else begin
                for (int k = 0; k < NUM_PIPELINE; k++) fwd_q[k] <= fwd_d[k];
                crd_q <= crd_d;
            end
        end

        assign fwd_out   = fwd_q[NUM_PIPELINE-1];
        assign up.credit = crd_q[NUM_PIPELINE-1];
    end

    frame_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0]   flit_count_q, flit_count_d;
    logic [CNT_WIDTH-1:0]   packet_count_q, packet_count_d;

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            flit_count_q   <= '0;
            packet_count_q <= '0;
        end else begin
            state_q        <= state_d;
            flit_count_q   <= flit_count_d;
            packet_count_q <= packet_count_d;
        end
    end

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        if (up.send) begin
            case (state_q)
                IDLE:    state_d = up.is_tail ? IDLE : OPEN;
                OPEN:    state_d = up.is_tail ? IDLE : OPEN;
                default: state_d = IDLE;
            endcase
        end
        flit_count_d   = flit_count_q + CNT_WIDTH'(up.send);
        packet_count_d = packet_count_q + CNT_WIDTH'(up.send & up.is_tail);
    end

    always_comb begin
        in_packet    = (state_q == OPEN);
        flit_count   = flit_count_q;
        packet_count = packet_count_q;
    end

`ifdef NOC_LINK_CREDIT_CHECK_EN
    localparam int CRED_W = $clog2(FLIT_BUFFER_DEPTH + 1) + 1;
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FLIT_BUFFER_DEPTH);

    logic [CRED_W-1:0] cred_q, cred_d;
    logic              err_q, err_d;
    logic [CRED_W:0]   cred_sum;
    logic              overrun;
    logic              spurious;

    // Credits the downstream buffer still has free, seen from the link output.
    always_comb begin
        cred_sum = {1'b0, cred_q} + {{CRED_W{1'b0}}, dn.credit} - {{CRED_W{1'b0}}, dn.send};
        overrun  = dn.send && (cred_q == '0) && !dn.credit;
        spurious = !overrun && (cred_sum > {1'b0, CRED_MAX});
        if (overrun)       cred_d = '0;
        else if (spurious) cred_d = CRED_MAX;
        else               cred_d = cred_sum[CRED_W-1:0];
        err_d = err_q | overrun | spurious;
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            cred_q <= CRED_MAX;
            err_q  <= 1'b0;
        end else begin
            cred_q <= cred_d;
            err_q  <= err_d;
        end
    end

    assign credit_err = err_q;

    a_credit_protocol: assert property (@(posedge clk_noc) disable iff (!rst_n) !(overrun || spurious))
        else $error("noc_pipeline_link: credit protocol violation (overrun=%0b spurious=%0b)", overrun, spurious);
`else
    assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_pipeline_link.sv
// Directed self-checking bench for noc_pipeline_link: latency, streaming, credits, framing,
// counter wrap, pass-through build, mid-packet reset and the optional credit checker.
module tb_noc_pipeline_link;

`ifdef NOC_LINK_CREDIT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk_noc = 1'b0;
    logic rst_n   = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    int   exp_flits = 0;
    int   exp_pkts  = 0;

    always #5 clk_noc = ~clk_noc;

    noc_link_if #(.FLIT_WIDTH(128), .DEST_WIDTH(6)) up2 ();
    noc_link_if #(.FLIT_WIDTH(128), .DEST_WIDTH(6)) dn2 ();
    noc_link_if #(.FLIT_WIDTH(128), .DEST_WIDTH(6)) up0 ();
    noc_link_if #(.FLIT_WIDTH(128), .DEST_WIDTH(6)) dn0 ();
    noc_link_if #(.FLIT_WIDTH(128), .DEST_WIDTH(6)) up4 ();
    noc_link_if #(.FLIT_WIDTH(128), .DEST_WIDTH(6)) dn4 ();

    logic        in_packet2, in_packet0, in_packet4;
    logic [31:0] flit_count2, packet_count2, flit_count0, packet_count0;
    logic [3:0]  flit_count4, packet_count4;
    logic        credit_err2, credit_err0, credit_err4;

    noc_pipeline_link #(.NUM_PIPELINE(2), .FLIT_WIDTH(128), .DEST_WIDTH(6),
                        .FLIT_BUFFER_DEPTH(1), .CNT_WIDTH(32)) u_dut (
        .clk_noc(clk_noc), .rst_n(rst_n), .up(up2), .dn(dn2), .in_packet(in_packet2),
        .flit_count(flit_count2), .packet_count(packet_count2), .credit_err(credit_err2));

    noc_pipeline_link #(.NUM_PIPELINE(0), .FLIT_WIDTH(128), .DEST_WIDTH(6),
                        .FLIT_BUFFER_DEPTH(1), .CNT_WIDTH(32)) u_dut0 (
        .clk_noc(clk_noc), .rst_n(rst_n), .up(up0), .dn(dn0), .in_packet(in_packet0),
        .flit_count(flit_count0), .packet_count(packet_count0), .credit_err(credit_err0));

    noc_pipeline_link #(.NUM_PIPELINE(2), .FLIT_WIDTH(128), .DEST_WIDTH(6),
                        .FLIT_BUFFER_DEPTH(1), .CNT_WIDTH(4)) u_dut4 (
        .clk_noc(clk_noc), .rst_n(rst_n), .up(up4), .dn(dn4), .in_packet(in_packet4),
        .flit_count(flit_count4), .packet_count(packet_count4), .credit_err(credit_err4));

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic test_reset();
        up2.send = 1'b1; up2.is_tail = 1'b0; up2.data = {16{8'h3C}}; up2.dest = 6'h2A;
        dn2.credit = 1'b1;
        tick(); tick();
        checks++; if (dn2.send !== 1'b0) begin errors++; $display("FAIL reset_send_out: got %b want 0", dn2.send); end
        checks++; if (up2.credit !== 1'b0) begin errors++; $display("FAIL reset_credit_out: got %b want 0", up2.credit); end
        checks++; if (dn2.data !== 128'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", dn2.data); end
        checks++; if (flit_count2 !== 32'd0) begin errors++; $display("FAIL reset_flit_count: got %0d want 0", flit_count2); end
        checks++; if (packet_count2 !== 32'd0) begin errors++; $display("FAIL reset_packet_count: got %0d want 0", packet_count2); end
        checks++; if (in_packet2 !== 1'b0) begin errors++; $display("FAIL reset_in_packet: got %b want 0", in_packet2); end
        up2.send = 1'b0; dn2.credit = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        up2.send = 1'b1; up2.is_tail = 1'b1; up2.data = {16{8'hA5}}; up2.dest = 6'h12;
        tick();
        up2.send = 1'b0; up2.is_tail = 1'b0; up2.data = '0; up2.dest = '0;
        checks++; if (dn2.send !== 1'b0) begin errors++; $display("FAIL lat_t1_send: got %b want 0", dn2.send); end
        tick();
        checks++; if (dn2.send !== 1'b1) begin errors++; $display("FAIL lat_t2_send: got %b want 1", dn2.send); end
        checks++; if (dn2.data !== {16{8'hA5}}) begin errors++; $display("FAIL lat_t2_data: got %h want %h", dn2.data, {16{8'hA5}}); end
        checks++; if (dn2.dest !== 6'h12) begin errors++; $display("FAIL lat_t2_dest: got %h want 12", dn2.dest); end
        checks++; if (dn2.is_tail !== 1'b1) begin errors++; $display("FAIL lat_t2_tail: got %b want 1", dn2.is_tail); end
        tick();
        checks++; if (dn2.send !== 1'b0) begin errors++; $display("FAIL lat_t3_send: got %b want 0", dn2.send); end
        exp_flits += 1; exp_pkts += 1;
        checks++; if (flit_count2 !== 32'(exp_flits)) begin errors++; $display("FAIL lat_flit_count: got %0d want %0d", flit_count2, exp_flits); end
        checks++; if (packet_count2 !== 32'(exp_pkts)) begin errors++; $display("FAIL lat_packet_count: got %0d want %0d", packet_count2, exp_pkts); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_data;
        for (int i = 0; i < 8; i++) begin
            up2.send = 1'b1; up2.data = {4{32'hC0DE0000 + 32'(i)}};
            up2.dest = 6'(i + 1); up2.is_tail = (i == 7);
            tick();
            checks++; if (in_packet2 !== (i != 7)) begin errors++; $display("FAIL b2b_in_packet[%0d]: got %b want %b", i, in_packet2, (i != 7)); end
            checks++; if (dn2.send !== (i >= 1)) begin errors++; $display("FAIL b2b_send[%0d]: got %b want %b", i, dn2.send, (i >= 1)); end
            if (i >= 1) begin
                exp_data = {4{32'hC0DE0000 + 32'(i - 1)}};
                checks++; if (dn2.data !== exp_data) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, dn2.data, exp_data); end
                checks++; if (dn2.dest !== 6'(i)) begin errors++; $display("FAIL b2b_dest[%0d]: got %h want %h", i, dn2.dest, 6'(i)); end
            end
        end
        up2.send = 1'b0; up2.is_tail = 1'b0;
        tick();
        exp_data = {4{32'hC0DE0007}};
        checks++; if (dn2.send !== 1'b1 || dn2.data !== exp_data) begin errors++; $display("FAIL b2b_last: send=%b data=%h want 1 %h", dn2.send, dn2.data, exp_data); end
        checks++; if (dn2.is_tail !== 1'b1) begin errors++; $display("FAIL b2b_last_tail: got %b want 1", dn2.is_tail); end
        tick();
        checks++; if (dn2.send !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", dn2.send); end
        exp_flits += 8; exp_pkts += 1;
        checks++; if (flit_count2 !== 32'(exp_flits)) begin errors++; $display("FAIL b2b_flit_count: got %0d want %0d", flit_count2, exp_flits); end
        checks++; if (packet_count2 !== 32'(exp_pkts)) begin errors++; $display("FAIL b2b_packet_count: got %0d want %0d", packet_count2, exp_pkts); end
    endtask

    task automatic test_credit_return();
        logic exp_crd;
        for (int c = 0; c < 19; c++) begin
            dn2.credit = (c == 10 || c == 11 || c == 14);
            up2.send = (c == 10); up2.is_tail = (c == 10); up2.data = {8{16'h7711}}; up2.dest = 6'h05;
            exp_crd = (c == 12 || c == 13 || c == 16);
            checks++; if (up2.credit !== exp_crd) begin errors++; $display("FAIL credit_out[c%0d]: got %b want %b", c, up2.credit, exp_crd); end
            checks++; if (dn2.send !== (c == 12)) begin errors++; $display("FAIL credit_send_out[c%0d]: got %b want %b", c, dn2.send, (c == 12)); end
            if (c == 12) begin
                checks++; if (dn2.data !== {8{16'h7711}}) begin errors++; $display("FAIL credit_data: got %h want %h", dn2.data, {8{16'h7711}}); end
            end
            tick();
        end
        up2.send = 1'b0; up2.is_tail = 1'b0; dn2.credit = 1'b0;
        exp_flits += 1; exp_pkts += 1;
    endtask

    task automatic test_single_flit_packets();
        for (int i = 0; i < 3; i++) begin
            up2.send = 1'b1; up2.is_tail = 1'b1; up2.data = 128'(i); up2.dest = 6'(i);
            tick();
            checks++; if (in_packet2 !== 1'b0) begin errors++; $display("FAIL single_in_packet[%0d]: got %b want 0", i, in_packet2); end
        end
        up2.send = 1'b0; up2.is_tail = 1'b0;
        tick();
        exp_flits += 3; exp_pkts += 3;
        checks++; if (packet_count2 !== 32'(exp_pkts)) begin errors++; $display("FAIL single_packet_count: got %0d want %0d", packet_count2, exp_pkts); end
        checks++; if (flit_count2 !== 32'(exp_flits)) begin errors++; $display("FAIL single_flit_count: got %0d want %0d", flit_count2, exp_flits); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) begin
            up4.send = 1'b1; up4.is_tail = 1'b1; up4.data = 128'(i); up4.dest = 6'(i);
            tick();
            if (i == 15) begin
                checks++; if (flit_count4 !== 4'd0) begin errors++; $display("FAIL wrap_flit_count16: got %0d want 0", flit_count4); end
            end
        end
        up4.send = 1'b0; up4.is_tail = 1'b0;
        tick();
        checks++; if (flit_count4 !== 4'd1) begin errors++; $display("FAIL wrap_flit_count17: got %0d want 1", flit_count4); end
        checks++; if (packet_count4 !== 4'd1) begin errors++; $display("FAIL wrap_packet_count17: got %0d want 1", packet_count4); end
    endtask

    task automatic test_passthrough();
        logic [127:0] exp_data;
        logic [5:0]   exp_dest;
        logic         exp_send, exp_tail, exp_crd;
        for (int v = 0; v < 3; v++) begin
            exp_data = {4{32'h12340000 + 32'(v)}};
            exp_dest = 6'(v * 5 + 3);
            exp_send = (v != 1);
            exp_tail = (v == 1 || v == 2);
            exp_crd  = (v != 0);
            up0.data = exp_data; up0.dest = exp_dest; up0.send = exp_send; up0.is_tail = exp_tail;
            dn0.credit = exp_crd;
            #1;
            checks++; if (dn0.data !== exp_data) begin errors++; $display("FAIL pass_data[%0d]: got %h want %h", v, dn0.data, exp_data); end
            checks++; if (dn0.dest !== exp_dest || dn0.send !== exp_send || dn0.is_tail !== exp_tail) begin
                errors++; $display("FAIL pass_ctrl[%0d]: got dest=%h send=%b tail=%b want %h %b %b", v, dn0.dest, dn0.send, dn0.is_tail, exp_dest, exp_send, exp_tail);
            end
            checks++; if (up0.credit !== exp_crd) begin errors++; $display("FAIL pass_credit[%0d]: got %b want %b", v, up0.credit, exp_crd); end
        end
        up0.send = 1'b0; up0.is_tail = 1'b0; dn0.credit = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        up2.send = 1'b1; up2.is_tail = 1'b0; up2.data = {16{8'hE1}}; up2.dest = 6'h01;
        tick();
        up2.data = {16{8'hE2}}; up2.dest = 6'h02;
        tick();
        up2.send = 1'b0;
        checks++; if (dn2.send !== 1'b1 || in_packet2 !== 1'b1) begin errors++; $display("FAIL midrst_pre: send=%b in_packet=%b want 1 1", dn2.send, in_packet2); end
        rst_n = 1'b0;
        #1;
        checks++; if (dn2.send !== 1'b0) begin errors++; $display("FAIL midrst_send_now: got %b want 0", dn2.send); end
        checks++; if (in_packet2 !== 1'b0) begin errors++; $display("FAIL midrst_in_packet: got %b want 0", in_packet2); end
        tick();
        rst_n = 1'b1;
        exp_flits = 0; exp_pkts = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dn2.send !== 1'b0) begin errors++; $display("FAIL midrst_ghost[%0d]: got %b want 0", i, dn2.send); end
        end
        checks++; if (flit_count2 !== 32'(exp_flits) || in_packet2 !== 1'b0) begin
            errors++; $display("FAIL midrst_post: flit_count=%0d in_packet=%b want 0 0", flit_count2, in_packet2);
        end
    endtask

    task automatic test_credit_check();
        up2.send = 1'b1; up2.is_tail = 1'b0; up2.data = {16{8'hC1}}; up2.dest = 6'h03;
        tick();
        up2.data = {16{8'hC2}};
        tick();
        up2.send = 1'b0;
        tick();
        checks++; if (credit_err2 !== 1'b0) begin errors++; $display("FAIL cchk_first_send: got %b want 0", credit_err2); end
        tick();
        checks++; if (credit_err2 !== CHK_EN) begin errors++; $display("FAIL cchk_overrun: got %b want %b", credit_err2, CHK_EN); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (credit_err2 !== CHK_EN) begin errors++; $display("FAIL cchk_sticky[%0d]: got %b want %b", i, credit_err2, CHK_EN); end
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (credit_err2 !== 1'b0) begin errors++; $display("FAIL cchk_reset_clear: got %b want 0", credit_err2); end
        tick();
        dn2.credit = 1'b1;
        tick();
        dn2.credit = 1'b0;
        checks++; if (credit_err2 !== CHK_EN) begin errors++; $display("FAIL cchk_spurious: got %b want %b", credit_err2, CHK_EN); end
        tick();
        checks++; if (credit_err2 !== CHK_EN) begin errors++; $display("FAIL cchk_spurious_sticky: got %b want %b", credit_err2, CHK_EN); end
    endtask

    initial begin
        up2.send = 1'b0; up2.is_tail = 1'b0; up2.data = '0; up2.dest = '0; dn2.credit = 1'b0;
        up0.send = 1'b0; up0.is_tail = 1'b0; up0.data = '0; up0.dest = '0; dn0.credit = 1'b0;
        up4.send = 1'b0; up4.is_tail = 1'b0; up4.data = '0; up4.dest = '0; dn4.credit = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_credit_return();
        test_single_flit_packets();
        test_wrap();
        test_passthrough();
        test_mid_reset();
        test_credit_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
